transform_dc_buffer: RTL and testbench

//  Per-macroblock DC coefficient store between the DC Hadamard/IQ stage and the 4x4 AC IDCT.

---
 rtl/transform_dc_pkg.sv | 44 ++++
 rtl/transform_dc_bank.sv | 47 ++++
 rtl/transform_dc_buffer.sv | 157 +++++++++++++++
 tb/tb_transform_dc_buffer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transform_dc_pkg.sv
// Shared channel/occupancy types, scan-to-raster remap tables and the rounding/clip helpers
// used by the per-macroblock DC coefficient buffer.
package transform_dc_pkg;

  typedef enum logic [1:0] {
    CH_LUMA = 2'd0,
    CH_CB   = 2'd1,
    CH_CR   = 2'd2
  } ch_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  // Lane -> raster index, 4 bits per lane, lane 0 in the LSBs.
  localparam logic [63:0] LUMA_MAP = {4'd15, 4'd14, 4'd11, 4'd10, 4'd13, 4'd12, 4'd9, 4'd8,
                                      4'd7,  4'd6,  4'd3,  4'd2,  4'd5,  4'd4,  4'd1, 4'd0};
  // Lane -> index inside one 2x2 chroma quad, 2 bits per lane, lane 0 in the LSBs.
  localparam logic [7:0]  CHROMA_MAP = {2'd1, 2'd3, 2'd2, 2'd0};

  // 4:2:2 chroma is two stacked quads, so the upper four lanes land at +4.
  function automatic int map_lane(input int lane, input bit is_luma);
    if (is_luma) return int'(LUMA_MAP[lane*4 +: 4]);
    return (lane / 4) * 4 + int'(CHROMA_MAP[(lane % 4)*2 +: 2]);
  endfunction

  // Operands arrive sign-extended to 32 bits, which leaves headroom for the rounding add.
  function automatic logic signed [31:0] round_shift(input logic signed [31:0] x, input int s);
    return (x + (32'sd1 <<< (s - 1))) >>> s;
  endfunction

  function automatic logic signed [31:0] clip_val(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 2)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 2));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/transform_dc_bank.sv
// Storage for one channel's DC block: remaps scan-order lanes to raster order on write.
// TRANSFORM_DC_CLIP_EN: clip each lane to [-2^(DW-2), 2^(DW-2)-1] before it is stored.
module transform_dc_bank
  import transform_dc_pkg::*;
#(
  parameter int DW      = 16,
  parameter int N       = 16,
  parameter bit IS_LUMA = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [N*DW-1:0] wr_data,
  input  logic [3:0]      rd_idx,
  output logic [DW-1:0]   rd_data,
  output logic            rd_oob
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N*DW-1:0] store;
  logic [N*DW-1:0] remap;
  logic [DW-1:0]   lane;

  always_comb begin
    remap = '0;
    lane  = '0;
    for (int i = 0; i < N; i++) begin
      lane = wr_data[i*DW +: DW];
`ifdef TRANSFORM_DC_CLIP_EN
      lane = DW'(clip_val(32'(signed'(lane)), DW));
`endif
      remap[map_lane(i, IS_LUMA)*DW +: DW] = lane;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     store <= '0;
    else if (clr)   store <= '0;
    else if (wr_en) store <= remap;
  end

  assign rd_oob  = (32'(rd_idx) >= N);
  assign rd_data = rd_oob ? '0 : store[rd_idx[IW-1:0]*DW +: DW];

endmodule

// File: rtl/transform_dc_buffer.sv
// Per-macroblock DC coefficient buffer (luma, Cb, Cr) with occupancy tracking and
// 1-cycle indexed reads; optional write clipping under TRANSFORM_DC_CLIP_EN.
//   state       | meaning
//   OCC_EMPTY   | nothing loaded since clr/reset
//   OCC_PARTIAL | some expected channels loaded
//   OCC_FULL    | every expected channel loaded (mb_full)
module transform_dc_buffer
  import transform_dc_pkg::*;
#(
  parameter int DW        = 16,
  parameter int LUMA_N    = 16,
  parameter int CHROMA_N  = 4,
  parameter int RND_SHIFT = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 clr,
  input  logic                 chroma_en,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [1:0]           wr_ch,
  input  logic [LUMA_N*DW-1:0] wr_data,
  input  logic                 rd_req,
  input  logic [1:0]           rd_ch,
  input  logic [3:0]           rd_idx,
  input  logic                 rd_round,
  output logic                 rd_valid,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_miss,
  output logic [2:0]           ch_vld,
  output logic                 mb_full
);

  occ_state_t state_q, state_d;
  logic [2:0] ch_vld_q, ch_vld_d;
  logic       chroma_q, chroma_d;
  logic       live_q;
  logic       wr_acc;
  logic [3:0] wr_busy;
  logic [3:0] rd_loaded;
  logic [2:0] expect_vld;

  logic [DW-1:0] luma_rd, cb_rd, cr_rd;
  logic          luma_oob, cb_oob, cr_oob;
  logic [DW-1:0] raw;
  logic          oob;
  logic [DW-1:0] rd_data_d;
  logic          rd_miss_d;

  // Keeps wr_ready low while reset is held and on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  // Reserved channel 3 reads as permanently loaded so it can never be written.
  assign wr_busy    = {1'b1, ch_vld_q};
  assign rd_loaded  = {1'b0, ch_vld_q};
  assign expect_vld = chroma_q ? 3'b111 : 3'b001;

  assign wr_ready = live_q & ena & ~clr & ~wr_busy[wr_ch] & ((wr_ch == CH_LUMA) | chroma_q);
  assign wr_acc   = wr_valid & wr_ready;

  always_comb begin
    state_d  = state_q;
    ch_vld_d = ch_vld_q;
    chroma_d = chroma_q;
    if (clr) begin
      state_d  = OCC_EMPTY;
      ch_vld_d = '0;
      chroma_d = chroma_en;
    end else if (wr_acc) begin
      ch_vld_d = ch_vld_q | (3'b001 << wr_ch);
      state_d  = (ch_vld_d == expect_vld) ? OCC_FULL : OCC_PARTIAL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OCC_EMPTY;
      ch_vld_q <= '0;
      chroma_q <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      ch_vld_q <= ch_vld_d;
      chroma_q <= chroma_d;
    end
  end

  assign ch_vld  = ch_vld_q;
  assign mb_full = (state_q == OCC_FULL);

  transform_dc_bank #(.DW(DW), .N(LUMA_N), .IS_LUMA(1'b1)) u_luma (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr & ena),
    .wr_en   (wr_acc & (wr_ch == CH_LUMA)),
    .wr_data (wr_data),
    .rd_idx  (rd_idx),
    .rd_data (luma_rd),
    .rd_oob  (luma_oob)
  );

  transform_dc_bank #(.DW(DW), .N(CHROMA_N), .IS_LUMA(1'b0)) u_cb (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr & ena),
    .wr_en   (wr_acc & (wr_ch == CH_CB)),
    .wr_data (wr_data[CHROMA_N*DW-1:0]),
    .rd_idx  (rd_idx),
    .rd_data (cb_rd),
    .rd_oob  (cb_oob)
  );

  transform_dc_bank #(.DW(DW), .N(CHROMA_N), .IS_LUMA(1'b0)) u_cr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr & ena),
    .wr_en   (wr_acc & (wr_ch == CH_CR)),
    .wr_data (wr_data[CHROMA_N*DW-1:0]),
    .rd_idx  (rd_idx),
    .rd_data (cr_rd),
    .rd_oob  (cr_oob)
  );

  // Banks are read before this edge's write/clear lands, so reads see the old contents.
  always_comb begin
    raw = '0;
    oob = 1'b1;
    case (rd_ch)
      CH_LUMA: begin raw = luma_rd; oob = luma_oob; end
      CH_CB:   begin raw = cb_rd;   oob = cb_oob;   end
      CH_CR:   begin raw = cr_rd;   oob = cr_oob;   end
      default: ;
    endcase
    rd_miss_d = oob | ~rd_loaded[rd_ch];
    rd_data_d = rd_miss_d ? '0
              : rd_round  ? DW'(round_shift(32'(signed'(raw)), RND_SHIFT))
              :             raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_miss  <= 1'b0;
    end else begin
      rd_valid <= rd_req & ena;
      if (rd_req & ena) begin
        rd_data <= rd_data_d;
        rd_miss <= rd_miss_d;
      end
    end
  end

endmodule

// File: tb/tb_transform_dc_buffer.sv
// Scoreboard bench for transform_dc_buffer: directed scenarios followed by random traffic,
// checked against an array-based model of the channel stores.
`timescale 1ns/1ps
module tb_transform_dc_buffer;
  localparam int DW        = 16;
  localparam int LUMA_N    = 16;
  localparam int CHROMA_N  = 4;
  localparam int RND_SHIFT = 6;
  localparam int LW        = LUMA_N * DW;

  logic          clk = 1'b0, rst_n = 1'b0, ena = 1'b0, clr = 1'b0, chroma_en = 1'b0;
  logic          wr_valid = 1'b0, rd_req = 1'b0, rd_round = 1'b0;
  logic [1:0]    wr_ch = 2'd0, rd_ch = 2'd0;
  logic [LW-1:0] wr_data = '0;
  logic [3:0]    rd_idx = 4'd0;
  logic          wr_ready, rd_valid, rd_miss, mb_full;
  logic [DW-1:0] rd_data;
  logic [2:0]    ch_vld;

  transform_dc_buffer #(.DW(DW), .LUMA_N(LUMA_N), .CHROMA_N(CHROMA_N), .RND_SHIFT(RND_SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .chroma_en(chroma_en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_data(wr_data),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_round(rd_round),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_miss(rd_miss),
    .ch_vld(ch_vld), .mb_full(mb_full)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] mon_e;

  int m_mem[3][16];
  bit m_vld[3];
  bit m_chroma;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Luma scan walks four 2x2 quads in Z order; chroma quad order is TL, BL, BR, TR.
  function automatic int raster_of(input int ch, input int lane);
    int b, q;
    q = lane % 4;
    if (ch == 0) begin
      b = lane / 4;
      return (b / 2) * 8 + (b % 2) * 2 + (q / 2) * 4 + (q % 2);
    end
    return (lane / 4) * 4 + ((q == 0) ? 0 : (q == 1) ? 2 : (q == 2) ? 3 : 1);
  endfunction

  function automatic int store_val(input logic [DW-1:0] x);
    int v;
    v = int'($signed(x));
`ifdef TRANSFORM_DC_CLIP_EN
    if (v > (1 << (DW-2)) - 1) v = (1 << (DW-2)) - 1;
    if (v < -(1 << (DW-2)))    v = -(1 << (DW-2));
`endif
    return v;
  endfunction

  function automatic logic [DW:0] exp_read(input int ch, input int idx, input bit rnd);
    int size, v;
    if (ch == 3) return {1'b1, {DW{1'b0}}};
    size = (ch == 0) ? LUMA_N : CHROMA_N;
    if (!m_vld[ch] || idx >= size) return {1'b1, {DW{1'b0}}};
    v = m_mem[ch][idx];
    if (rnd) v = int'($floor(real'(v) / real'(1 << RND_SHIFT) + 0.5));
    return {1'b0, DW'(v)};
  endfunction

  function automatic bit model_ready();
    if (!ena || clr || wr_ch == 2'd3) return 1'b0;
    if (m_vld[wr_ch]) return 1'b0;
    if (wr_ch != 2'd0 && !m_chroma) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_full();
    return m_vld[0] && (!m_chroma || (m_vld[1] && m_vld[2]));
  endfunction

  task automatic model_reset();
    foreach (m_mem[c, i]) m_mem[c][i] = 0;
    m_vld    = '{0, 0, 0};
    m_chroma = 1'b0;
  endtask

  // Called just after a negedge with inputs set; checks, predicts, then advances one cycle.
  task automatic tick();
    bit rdy;
    int size;
    #1;
    rdy = model_ready();
    chk("wr_ready", 32'(wr_ready), 32'(rdy));
    chk("ch_vld", 32'(ch_vld), 32'({m_vld[2], m_vld[1], m_vld[0]}));
    chk("mb_full", 32'(mb_full), 32'(model_full()));
    if (rd_req && ena) exp_q.push_back(exp_read(int'(rd_ch), int'(rd_idx), rd_round));
    if (ena) begin
      if (clr) begin
        foreach (m_mem[c, i]) m_mem[c][i] = 0;
        m_vld    = '{0, 0, 0};
        m_chroma = chroma_en;
      end else if (wr_valid && rdy) begin
        size = (wr_ch == 2'd0) ? LUMA_N : CHROMA_N;
        for (int i = 0; i < size; i++)
          m_mem[wr_ch][raster_of(int'(wr_ch), i)] = store_val(wr_data[i*DW +: DW]);
        m_vld[wr_ch] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_clr(input bit ce);
    clr = 1'b1; chroma_en = ce; tick(); clr = 1'b0;
  endtask

  task automatic do_write(input int ch, input logic [LW-1:0] d);
    wr_valid = 1'b1; wr_ch = 2'(ch); wr_data = d; tick(); wr_valid = 1'b0;
  endtask

  task automatic do_read(input int ch, input int idx, input bit rnd);
    rd_req = 1'b1; rd_ch = 2'(ch); rd_idx = 4'(idx); rd_round = rnd; tick(); rd_req = 1'b0;
  endtask

  function automatic logic [LW-1:0] rand_data();
    logic [LW-1:0] d;
    for (int i = 0; i < LUMA_N; i++) d[i*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected actual miss=%0b data=%0h expected no rd_valid", rd_miss, rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rd_miss, rd_data} !== mon_e) begin
          fails++;
          $display("FAIL rd_result actual miss=%0b data=%0h expected miss=%0b data=%0h",
                   rd_miss, rd_data, mon_e[DW], mon_e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    logic [LW-1:0] d;
    model_reset();
    ena = 1'b1; wr_valid = 1'b1; wr_ch = 2'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_miss", 32'(rd_miss), 32'd0);
    chk("rst_ch_vld", 32'(ch_vld), 32'd0);
    chk("rst_mb_full", 32'(mb_full), 32'd0);
    @(negedge clk);
    wr_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: luma-only MB, lanes i*10
    do_clr(1'b0);
    for (int i = 0; i < LUMA_N; i++) d[i*DW +: DW] = DW'(i * 10);
    do_write(0, d);
    do_read(0, 2, 1'b0);
    do_read(0, 12, 1'b0);
    do_read(0, 15, 1'b0);

    // 2: chroma MB, Cb lanes {7,8,9,10}; Cb read in its own write cycle sees the old state
    do_clr(1'b1);
    do_write(0, rand_data());
    d = '0;
    for (int i = 0; i < 4; i++) d[i*DW +: DW] = DW'(7 + i);
    rd_req = 1'b1; rd_ch = 2'd1; rd_idx = 4'd1; rd_round = 1'b0;
    do_write(1, d);
    rd_req = 1'b0;
    do_read(1, 1, 1'b0);
    do_read(1, 3, 1'b0);
    do_write(2, rand_data());
    do_read(2, 0, 1'b0);

    // 3: rounding of -96, 95, 32, 31
    do_clr(1'b0);
    d = '0;
    d[0*DW +: DW] = DW'(-96);
    d[1*DW +: DW] = DW'(95);
    d[2*DW +: DW] = DW'(32);
    d[3*DW +: DW] = DW'(31);
    do_write(0, d);
    for (int r = 0; r < 6; r++) do_read(0, r, 1'b1);
    do_read(0, 0, 1'b0);

    // 4: second luma write stalls; clr beats a simultaneous write
    do_write(0, rand_data());
    clr = 1'b1; chroma_en = 1'b0; wr_valid = 1'b1; wr_ch = 2'd0; wr_data = rand_data();
    rd_req = 1'b1; rd_ch = 2'd0; rd_idx = 4'd4; rd_round = 1'b0;
    tick();
    clr = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
    do_read(0, 4, 1'b0);

    // 5: out-of-range Cr index, unloaded Cb, reserved channel
    do_clr(1'b1);
    do_write(0, rand_data());
    do_write(2, rand_data());
    do_read(2, 5, 1'b0);
    do_read(1, 0, 1'b0);
    do_read(3, 0, 1'b0);
    do_read(2, 3, 1'b0);
    do_write(3, rand_data());

    // 6: ena low mid-load, then saturating value
    do_clr(1'b1);
    do_write(0, rand_data());
    do_read(0, 7, 1'b0);
    ena = 1'b0; wr_valid = 1'b1; wr_ch = 2'd1; wr_data = rand_data();
    rd_req = 1'b1; rd_ch = 2'd0; rd_idx = 4'd3; clr = 1'b0;
    repeat (3) tick();
    ena = 1'b1; rd_req = 1'b0;
    tick();
    wr_valid = 1'b0;
    do_read(1, 2, 1'b0);
    do_clr(1'b0);
    d = '0;
    d[0*DW +: DW] = 16'h7FFF;
    d[1*DW +: DW] = 16'h8000;
    do_write(0, d);
    do_read(0, 0, 1'b0);
    do_read(0, 1, 1'b0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      ena       = ($urandom_range(9) != 0);
      clr       = ($urandom_range(19) == 0);
      chroma_en = 1'($urandom_range(1));
      wr_valid  = 1'($urandom_range(1));
      wr_ch     = 2'($urandom_range(3));
      wr_data   = rand_data();
      rd_req    = 1'($urandom_range(1));
      rd_ch     = 2'($urandom_range(3));
      rd_idx    = 4'($urandom_range(15));
      rd_round  = 1'($urandom_range(1));
      tick();
    end
    ena = 1'b1; clr = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // async reset with a read in flight
    do_clr(1'b0);
    do_write(0, rand_data());
    rd_req = 1'b1; rd_ch = 2'd0; rd_idx = 4'd1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    rd_req = 1'b0;
    @(negedge clk);
    #1;
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    chk("arst_ch_vld", 32'(ch_vld), 32'd0);
    chk("arst_mb_full", 32'(mb_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_clr(1'b0);
    do_read(0, 0, 1'b0);
    repeat (2) tick();
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
